// File: rtl/lcd_lvds_timing.sv
// Raster timing generator with built-in test patterns, packed into FPD-Link lane words.
// Two register stages sit between the raster counters and the lane outputs.
module lcd_lvds_timing #(
    parameter int H_ACTIVE = 1366,
    parameter int H_FP     = 48,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 114,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic       lvdsClk,
    input  logic       rst,
    input  logic       run,
    input  logic [1:0] patSel,
    output logic [6:0] lane0,
    output logic [6:0] lane1,
    output logic [6:0] lane2,
    output logic [6:0] clkLane,
    output logic       frameStart,
    output logic       running
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Counters are at least 6 bits wide so the gradient/checker bit picks always exist.
    localparam int HW = ($clog2(H_TOTAL) > 6) ? $clog2(H_TOTAL) : 6;
    localparam int VW = ($clog2(V_TOTAL) > 6) ? $clog2(V_TOTAL) : 6;
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW = $clog2(BAR_W + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
    localparam logic HS_IDLE = (HS_POL == 0);
    localparam logic VS_IDLE = (VS_POL == 0);

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
    state_t state, stateNext;

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [BW-1:0] barCnt;
    logic [2:0]    barIdx;
    logic [1:0]    patReg, patCur;
    logic          frameWrap, origin, active;

    assign frameWrap = (hcnt == H_LAST) && (vcnt == V_LAST);
    assign origin    = (hcnt == '0) && (vcnt == '0);
    assign active    = (state != IDLE);
    assign patCur    = origin ? patSel : patReg;
    assign clkLane   = 7'b1100011;

    always_ff @(posedge lvdsClk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        running   = 1'b0;
        case (state)
            IDLE: if (run) stateNext = RUN;
            RUN: begin
                running = 1'b1;
                if (!run) stateNext = STOPPING;
            end
            STOPPING: begin
                running = 1'b1;
                if (run)            stateNext = RUN;
                else if (frameWrap) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Raster counters and the colour-bar sub-counter (avoids dividing hcnt by BAR_W).
    always_ff @(posedge lvdsClk or posedge rst) begin
        if (rst) begin
            hcnt   <= '0;
            vcnt   <= '0;
            barCnt <= '0;
            barIdx <= '0;
            patReg <= '0;
        end else begin
            if (origin) patReg <= patSel;
            if (!active) begin
                hcnt   <= '0;
                vcnt   <= '0;
                barCnt <= '0;
                barIdx <= '0;
            end else begin
                if (hcnt == H_LAST) begin
                    hcnt   <= '0;
                    vcnt   <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
                    barCnt <= '0;
                    barIdx <= '0;
                end else begin
                    hcnt <= hcnt + 1'b1;
                    if (barCnt == BAR_LAST) begin
                        barCnt <= '0;
                        barIdx <= barIdx + 1'b1;
                    end else begin
                        barCnt <= barCnt + 1'b1;
                    end
                end
            end
        end
    end

    logic       deNow, hsNow, vsNow;
    logic [5:0] redNow, greenNow, blueNow;

    always_comb begin
        deNow    = active && (hcnt < H_ACT) && (vcnt < V_ACT);
        hsNow    = (active && (hcnt >= HS_START) && (hcnt < HS_END)) ? ~HS_IDLE : HS_IDLE;
        vsNow    = (active && (vcnt >= VS_START) && (vcnt < VS_END)) ? ~VS_IDLE : VS_IDLE;
        redNow   = '0;
        greenNow = '0;
        blueNow  = '0;
        if (deNow) begin
            case (patCur)
                2'd1: begin
                    redNow   = {6{~barIdx[1]}};
                    greenNow = {6{~barIdx[2]}};
                    blueNow  = {6{~barIdx[0]}};
                end
                2'd2: begin
                    redNow   = hcnt[5:0];
                    greenNow = hcnt[5:0];
                    blueNow  = hcnt[5:0];
                end
                2'd3: begin
                    redNow   = {6{hcnt[5] ^ vcnt[5]}};
                    greenNow = {6{hcnt[5] ^ vcnt[5]}};
                    blueNow  = {6{hcnt[5] ^ vcnt[5]}};
                end
                default: ;
            endcase
        end
    end

    // Stage 1: pixel attributes
    logic       de_p1, hs_p1, vs_p1, fs_p1;
    logic [5:0] red_p1, green_p1, blue_p1;

    always_ff @(posedge lvdsClk or posedge rst) begin
        if (rst) begin
            de_p1    <= 1'b0;
            hs_p1    <= HS_IDLE;
            vs_p1    <= VS_IDLE;
            fs_p1    <= 1'b0;
            red_p1   <= '0;
            green_p1 <= '0;
            blue_p1  <= '0;
        end else begin
            de_p1    <= deNow;
            hs_p1    <= hsNow;
            vs_p1    <= vsNow;
            fs_p1    <= active && origin;
            red_p1   <= redNow;
            green_p1 <= greenNow;
            blue_p1  <= blueNow;
        end
    end

    // Stage 2: lane words
    always_ff @(posedge lvdsClk or posedge rst) begin
        if (rst) begin
            lane0      <= '0;
            lane1      <= '0;
            lane2      <= {1'b0, VS_IDLE, HS_IDLE, 4'b0000};
            frameStart <= 1'b0;
        end else begin
            lane0      <= {green_p1[0], red_p1};
            lane1      <= {blue_p1[1:0], green_p1[5:1]};
            lane2      <= {de_p1, vs_p1, hs_p1, blue_p1[5:2]};
            frameStart <= fs_p1;
        end
    end
endmodule

// File: tb/tb_lcd_lvds_timing.sv
// Scoreboard bench: a frame-position model pushes expected lane words, a monitor pops and compares.
module tb_lcd_lvds_timing;
    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
    localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int H_TOTAL = 14, V_TOTAL = 7, FRAME = 98;
    localparam int HS_POL = 0, VS_POL = 0;
    localparam bit [7:0] BAR_R = 8'b00110011;
    localparam bit [7:0] BAR_G = 8'b00001111;
    localparam bit [7:0] BAR_B = 8'b01010101;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic [1:0] patSel = 2'd0;
    logic [6:0] lane0, lane1, lane2, clkLane;
    logic       frameStart, running;

    lcd_lvds_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .lvdsClk(clk), .rst(rst), .run(run), .patSel(patSel),
        .lane0(lane0), .lane1(lane1), .lane2(lane2), .clkLane(clkLane),
        .frameStart(frameStart), .running(running)
    );

    always #5 clk = ~clk;

    logic [21:0] expQ[$];
    int  mPos = 0, mPat = 0;
    bit  mOn = 0, mStop = 0;
    int  checkCnt = 0, passCnt = 0, ncyc = 0;
    int  barReq = 0, barAck = 0, waitTimeouts = 0;
    bit  finishReq = 0;

    function automatic logic [21:0] pixelWord(input bit on, input int pos, input int pat);
        int h = pos % H_TOTAL;
        int v = pos / H_TOTAL;
        bit de = on && (h < H_ACTIVE) && (v < V_ACTIVE);
        bit hsOn = on && (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
        bit vsOn = on && (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
        bit hs = hsOn ? (HS_POL != 0) : (HS_POL == 0);
        bit vs = vsOn ? (VS_POL != 0) : (VS_POL == 0);
        logic [5:0] r = 0, g = 0, b = 0;
        int bar;
        if (de) begin
            case (pat)
                1: begin
                    bar = h / (H_ACTIVE / 8);
                    r = BAR_R[bar] ? 6'd63 : 6'd0;
                    g = BAR_G[bar] ? 6'd63 : 6'd0;
                    b = BAR_B[bar] ? 6'd63 : 6'd0;
                end
                2: begin
                    r = 6'(h % 64); g = r; b = r;
                end
                3: begin
                    r = (((h / 32) ^ (v / 32)) % 2 == 1) ? 6'd63 : 6'd0;
                    g = r; b = r;
                end
                default: ;
            endcase
        end
        return {g[0], r, b[1:0], g[5:1], de, vs, hs, b[5:2], on && (pos == 0)};
    endfunction

    // Reference model: one step per clock edge on the frame position.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mOn = 0; mPos = 0; mPat = 0; mStop = 0;
                expQ.delete();
                expQ.push_back(pixelWord(0, 0, 0));
            end else begin
                expQ.push_back(pixelWord(mOn, mPos, (mPos == 0) ? int'(patSel) : mPat));
                if (mPos == 0) mPat = int'(patSel);
                if (!mOn) begin
                    if (run) begin mOn = 1; mStop = 0; end
                end else begin
                    if (mPos == FRAME - 1 && mStop && !run) mOn = 0;
                    mStop = !run;
                    mPos = (mPos + 1) % FRAME;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checkCnt++;
        if (act === req) passCnt++;
        else $display("FAIL %s: got 'h%0h, required 'h%0h (cycle %0d)", name, act, req, ncyc);
    endtask

    // Monitor: compares DUT outputs at the falling edge.
    initial begin
        logic [21:0] exp;
        logic [6:0]  barLane0 [8];
        bit prevRun = 0, lastFsValid = 0, awaitFs = 0, barActive = 0;
        int lastFs = 0, riseCyc = 0, barPix = 0;
        barLane0 = '{7'b1111111, 7'b1111111, 7'b1000000, 7'b1000000,
                     7'b0111111, 7'b0111111, 7'b0000000, 7'b0000000};
        forever begin
            @(negedge clk);
            ncyc++;
            if (finishReq) begin
                check("barCheckDone", barAck, barReq);
                check("waitTimeouts", waitTimeouts, 0);
                $display("%0d/%0d checks passed", passCnt, checkCnt);
                $finish;
            end
            check("clkLane", clkLane, 7'b1100011);
            if (rst) begin
                check("resetLanes", {lane0, lane1, lane2}, {7'b0, 7'b0, 7'b0110000});
                check("resetFlags", {frameStart, running}, 2'b00);
                prevRun = 0; lastFsValid = 0; awaitFs = 0; barActive = 0;
            end else begin
                if (expQ.size() == 0) check("scoreboardEmpty", expQ.size(), 1);
                else begin
                    exp = expQ.pop_front();
                    check("laneWords", {lane0, lane1, lane2, frameStart}, exp);
                end
                check("running", running, mOn);
                if (running && !prevRun) begin riseCyc = ncyc; awaitFs = 1; end
                if (frameStart && awaitFs) begin
                    check("runToFrameStart", ncyc - riseCyc + 1, 3);
                    awaitFs = 0;
                end
                if (!running) lastFsValid = 0;
                else if (frameStart) begin
                    if (lastFsValid) check("framePeriod", ncyc - lastFs, FRAME);
                    lastFs = ncyc; lastFsValid = 1;
                end
                if (barActive) begin
                    check("barLane0", lane0, barLane0[barPix]);
                    barPix++;
                    if (barPix == 8) begin barActive = 0; barAck++; end
                end else if (frameStart && barReq != barAck) begin
                    check("barLane0", lane0, barLane0[0]);
                    barActive = 1; barPix = 1;
                end
                prevRun = running;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic waitPos(input int p);
        int i = 0;
        while (mPos != p && i < 300) begin tick(1); i++; end
        if (mPos != p) waitTimeouts++;
    endtask

    initial begin
        #1 rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        run = 1'b1;
        tick(3 * FRAME);
        patSel = 2'd1;
        tick(FRAME + 10);
        barReq++;
        tick(FRAME + 20);
        waitPos(40);
        patSel = 2'd2;
        tick(2 * FRAME);
        patSel = 2'd3;
        tick(FRAME + 30);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        run = 1'b0;
        tick(120);
        run = 1'b1;
        tick(5);
        waitPos(20);
        run = 1'b0;
        tick(30);
        run = 1'b1;
        tick(150);
        waitPos(20);
        run = 1'b0;
        tick(2 * FRAME);
        patSel = 2'd0;
        repeat (900) begin
            tick(1);
            if ($urandom_range(0, 39) == 0) run = ~run;
            if ($urandom_range(0, 29) == 0) patSel = 2'($urandom_range(0, 3));
        end
        finishReq = 1'b1;
        tick(5);
        $display("FAIL watchdog: monitor did not finish, got running bench, required summary");
        $fatal(1);
    end
endmodule
